alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Operand/opcode issue stage directly upstream of the 32-bit ALU (AND/OR/ADD, 4-bit select, carry-out and zero flag).
- Accepts operations on a valid/ready interface, decodes a 3-bit op into the ALU's 4-bit select, and holds operands in a 2-entry skid buffer.
- Drives A, B and ALU_Sel from registers, so the ALU's inputs are stable while its consumer stalls.

Parameters:
- WIDTH, 32, operand width; must match the ALU operand width.
- CNT_W, 16, width of the issued-operation counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  upstream offers an operation
- in_ready  output  1  stage can accept; transfer when in_valid && in_ready
- in_op  input  3  operation code
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  A/B/ALU_Sel hold a valid operation
- out_ready  input  1  ALU consumer takes it; transfer when out_valid && out_ready
- A  output  WIDTH  operand A to ALU
- B  output  WIDTH  operand B to ALU
- ALU_Sel  output  4  ALU select
- illegal  output  1  presented operation had an undefined in_op
- issue_cnt  output  CNT_W  count of completed output transfers

Behaviour:
- Op decode at accept:
  - 000 -> ALU_Sel 4'b0000 (AND)
  - 001 -> 4'b0001 (OR)
  - 010 -> 4'b0010 (ADD)
  - 011..111 -> ALU_Sel 4'b1111 with illegal=1. The ALU outputs 0 and z=1 for this select; the operation is still issued, never dropped.
- Storage: main register (drives outputs) plus skid register; each entry holds {A, B, ALU_Sel, illegal}.
- States:
  - EMPTY: main invalid.
  - ONE: main valid, skid invalid.
  - FULL: both valid.
- Ready and valid: in_ready = (state != FULL), decoded from the state register only, with no combinational path from out_ready. out_valid = (state != EMPTY).
- Transitions (acc = input transfer, tkn = output transfer):
  - EMPTY + acc -> ONE; the input loads main.
  - ONE + acc, no tkn -> FULL; the input loads skid.
  - ONE + tkn, no acc -> EMPTY.
  - ONE + acc + tkn -> ONE; the input loads main.
  - FULL + tkn -> ONE; skid moves to main. in_ready=0, so no acc is possible.
  - All other cases hold state.
- Latency: an accepted operation appears on the outputs the cycle after acceptance when the stage was EMPTY, or ONE with a simultaneous take.
- Ordering: strict FIFO order, with no loss or duplication under any in_valid/out_ready pattern.
- Output stability: A, B, ALU_Sel and illegal hold stable while out_valid && !out_ready. In EMPTY they hold their last value.
- issue_cnt: +1 per tkn, wraps from 2^CNT_W-1 to 0.
- Reset values, applied immediately on rst_n low:
  - state EMPTY; out_valid 0; in_ready 1.
  - A 0, B 0, ALU_Sel 4'b0000, illegal 0, issue_cnt 0.
  - Asserting reset mid-operation discards buffered entries; nothing is replayed after release.

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN.
- When defined, the stage adds these ports:
  - fwd_data  input  WIDTH
  - in_fwd_a  input  1
  - in_fwd_b  input  1
- With the macro, on acc, in_fwd_a=1 stores fwd_data instead of in_a, and in_fwd_b=1 stores fwd_data instead of in_b. Both flags set stores fwd_data into both operands.
- Without the macro, these ports do not exist and operands are stored unmodified.

Decomposition:
- Package alu_pkg holds:
  - the ALU select constants (AND 4'b0000, OR 4'b0001, ADD 4'b0010, NOP 4'b1111);
  - the op-code constants;
  - a state enum {EMPTY, ONE, FULL};
  - an entry struct {a, b, sel, illegal}.
- One sub-module, alu_op_decode: combinational 3-bit op -> {sel, illegal}.

Test Plan:
- Reset then accept op 010, A=5, B=7, with out_ready=1 -> next cycle out_valid=1, A=5, B=7, ALU_Sel=0010, illegal=0; issue_cnt=1 after take.
- out_ready=0; accept ops 000 (A=1) then 001 (A=2) -> state FULL, in_ready=0. Raise out_ready -> A=1 then A=2 on consecutive cycles, then out_valid=0.
- in_op=110 -> ALU_Sel=1111, illegal=1, still issued, and issue_cnt increments.
- Continuous in_valid with random out_ready over 1000 ops -> output sequence equals input sequence, and outputs never change while stalled.
- Assert rst_n low with the stage FULL, async between edges -> out_valid=0, in_ready=1, outputs 0 immediately; no stale op after release.
- issue_cnt preloaded near 16'hFFFF by 65535 takes, then one more take -> 0. With ALU_ISSUE_FWD_EN: in_fwd_b=1, fwd_data=9, in_b=3 -> B=9.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage.
//   - ALU select encodings and issue-stage op codes
//   - skid-buffer state enum and buffered entry payload
package alu_pkg;

   // Operand width of the downstream ALU; the issue stage WIDTH must equal this.
   localparam int unsigned DATA_W = 32;

   // ALU select encodings
   localparam logic [3:0] SEL_AND = 4'b0000;
   localparam logic [3:0] SEL_OR  = 4'b0001;
   localparam logic [3:0] SEL_ADD = 4'b0010;
   localparam logic [3:0] SEL_NOP = 4'b1111;

   // Issue op codes (all others are illegal)
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [3:0]        sel;
      logic              illegal;
   } entry_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational op decode: 3-bit issue op -> 4-bit ALU select plus illegal flag.
// Undefined ops map to the NOP select so they still flow through the ALU.
//   op        : issue op code
//   sel_c     : ALU select
//   illegal_c : op was undefined
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [2:0] op,
   output logic [3:0] sel_c,
   output logic       illegal_c
);

   always_comb begin
      sel_c     = SEL_NOP;
      illegal_c = 1'b1;
      unique case (op)
         OP_AND: begin sel_c = SEL_AND; illegal_c = 1'b0; end
         OP_OR:  begin sel_c = SEL_OR;  illegal_c = 1'b0; end
         OP_ADD: begin sel_c = SEL_ADD; illegal_c = 1'b0; end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand/opcode issue stage in front of the 32-bit ALU. Accepts ops on a
// valid/ready interface, decodes them and holds them in a 2-entry skid buffer
// (main register drives the ALU, skid register absorbs one extra op), so the
// ALU inputs stay stable while the consumer stalls.
// Optional macro ALU_ISSUE_FWD_EN adds fwd_data/in_fwd_a/in_fwd_b, which
// replace in_a/in_b with fwd_data at accept.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : upstream handshake; in_op, in_a, in_b payload
//   out_valid/out_ready   : ALU-side handshake
//   A, B, ALU_Sel, illegal: registered operation presented to the ALU
//   issue_cnt             : wrapping count of completed output transfers
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
`ifdef ALU_ISSUE_FWD_EN
   input  logic [WIDTH-1:0] fwd_data,
   input  logic             in_fwd_a,
   input  logic             in_fwd_b,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [3:0]       ALU_Sel,
   output logic             illegal,
   output logic [CNT_W-1:0] issue_cnt
);

   state_t           state_q, state_d;
   entry_t           main_q, main_d;
   entry_t           skid_q, skid_d;
   logic [CNT_W-1:0] cnt_d;
   logic             in_ready_d, out_valid_d;

   logic [3:0]       dec_sel;
   logic             dec_illegal;
   entry_t           in_entry;
   logic             acc, tkn;

   alu_op_decode u_dec (
      .op        (in_op),
      .sel_c     (dec_sel),
      .illegal_c (dec_illegal)
   );

   // Incoming entry, with optional operand forwarding
   always_comb begin
      in_entry.a       = DATA_W'(in_a);
      in_entry.b       = DATA_W'(in_b);
      in_entry.sel     = dec_sel;
      in_entry.illegal = dec_illegal;
`ifdef ALU_ISSUE_FWD_EN
      if (in_fwd_a) in_entry.a = DATA_W'(fwd_data);
      if (in_fwd_b) in_entry.b = DATA_W'(fwd_data);
`endif
   end

   assign acc = in_valid && in_ready;
   assign tkn = out_valid && out_ready;

   // Next-state, buffer movement and flag decode
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      cnt_d   = issue_cnt;

      unique case (state_q)
         EMPTY: begin
            if (acc) begin
               main_d  = in_entry;
               state_d = ONE;
            end
         end
         ONE: begin
            if (acc && !tkn) begin
               skid_d  = in_entry;
               state_d = FULL;
            end else if (!acc && tkn) begin
               state_d = EMPTY;
            end else if (acc && tkn) begin
               main_d  = in_entry;
            end
         end
         FULL: begin
            // in_ready is low here, so only the take can happen
            if (tkn) begin
               main_d  = skid_q;
               state_d = ONE;
            end
         end
         default: state_d = EMPTY;
      endcase

      if (tkn) cnt_d = issue_cnt + CNT_W'(1);

      // Handshake flags are registered copies of the next-state decode
      in_ready_d  = (state_d != FULL);
      out_valid_d = (state_d != EMPTY);
   end

   // State and payload registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= EMPTY;
         main_q    <= '0;
         skid_q    <= '0;
         issue_cnt <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         main_q    <= main_d;
         skid_q    <= skid_d;
         issue_cnt <= cnt_d;
         in_ready  <= in_ready_d;
         out_valid <= out_valid_d;
      end
   end

   assign A       = WIDTH'(main_q.a);
   assign B       = WIDTH'(main_q.b);
   assign ALU_Sel = main_q.sel;
   assign illegal = main_q.illegal;

endmodule
